// File: rtl/mc_ctrl_gen_if.sv
// mc_ctrl_gen_if: instruction fields, flags, memory handshake and datapath
// controls exchanged between the multi-cycle controller and the datapath.
// Handshake: the controller holds its memory request (FETCH, MEMRD, MEMWR)
// for as long as MemReady is low; the cycle in which MemReady is high
// completes the access, and only then are the access-completing enables
// (IRWrite/PCWrite in FETCH, InstrRetired in MEMWR) asserted.
// MemReady is honoured only in builds with MC_CTRL_MEMWAIT_EN defined.
interface mc_ctrl_gen_if #(
  parameter int REG_AW = 3
);
  // datapath -> controller
  logic              RUN;
  logic [1:0]        op;
  logic [2:0]        funct;
  logic [REG_AW-1:0] Rd;
  logic [2:0]        cond;
  logic              S;
  logic              Z;
  logic              CO;
  logic              MemReady;
  // controller -> datapath
  logic              PCWrite;
  logic              AdrSrc;
  logic              MemWrite;
  logic              IRWrite;
  logic              RegSrc1;
  logic              RegSrc2;
  logic              RegWrite;
  logic              ALUSrcA;
  logic              LRWrite;
  logic              WriteSelect;
  logic              FlagW1;
  logic              FlagW2;
  logic [1:0]        ALUSrcB;
  logic [2:0]        ALUControl;
  logic [2:0]        ResultSrc;
  logic [3:0]        StateNumber;
  logic              Halted;
  logic              IllegalOp;
  logic              InstrRetired;

  modport master (
    output RUN, op, funct, Rd, cond, S, Z, CO, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegSrc1, RegSrc2, RegWrite,
           ALUSrcA, LRWrite, WriteSelect, FlagW1, FlagW2, ALUSrcB,
           ALUControl, ResultSrc, StateNumber, Halted, IllegalOp, InstrRetired
  );

  modport slave (
    input  RUN, op, funct, Rd, cond, S, Z, CO, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegSrc1, RegSrc2, RegWrite,
           ALUSrcA, LRWrite, WriteSelect, FlagW1, FlagW2, ALUSrcB,
           ALUControl, ResultSrc, StateNumber, Halted, IllegalOp, InstrRetired
  );
endinterface

// File: rtl/mc_ctrl_gen.sv
// mc_ctrl_gen: multi-cycle fetch/decode/execute controller.
// Optional feature macro: MC_CTRL_MEMWAIT_EN -- when defined, FETCH, MEMRD
// and MEMWR wait for MemReady; otherwise every memory state lasts one cycle.
// The current state is visible on StateNumber.
module mc_ctrl_gen #(
  parameter int REG_AW = 3,
  parameter int PC_IDX = (1 << REG_AW) - 1
) (
  input logic         CLK,
  input logic         RESET,
  mc_ctrl_gen_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_LDI     = 4'd2,
    S_MEMADR  = 4'd3,
    S_ALU     = 4'd4,
    S_SHIFT   = 4'd5,
    S_BRANCH  = 4'd6,
    S_MEMRD   = 4'd7,
    S_MEMWB   = 4'd8,
    S_MEMWR   = 4'd9,
    S_ALUWB   = 4'd10,
    S_SHIFTWB = 4'd11,
    S_BXLR    = 4'd12,
    S_LINK    = 4'd13,
    S_HALT    = 4'd14
  } state_e;

  localparam logic [REG_AW-1:0] PC_ADDR = PC_IDX[REG_AW-1:0];

  state_e state_q;
  state_e state_d;

  logic mem_rdy;
  logic rd_is_pc;
  logic br_taken;
  logic illegal;

`ifdef MC_CTRL_MEMWAIT_EN
  assign mem_rdy = bus.MemReady;
`else
  // MemReady has no role without wait states; every access completes at once.
  logic unused_memready;
  assign unused_memready = bus.MemReady;
  assign mem_rdy = 1'b1;
`endif

  assign rd_is_pc = (bus.Rd == PC_ADDR);

  // Branch is suppressed only for the four flag-qualified conditions.
  assign br_taken = !(((bus.cond == 3'b001) && !bus.Z) ||
                      ((bus.cond == 3'b010) &&  bus.Z) ||
                      ((bus.cond == 3'b011) && !bus.CO) ||
                      ((bus.cond == 3'b100) &&  bus.CO));

  // Only op=11 has unused sub-ops; every other class decodes for any funct.
  assign illegal = (bus.op == 2'b11) &&
                   !((bus.funct == 3'b000) || (bus.funct == 3'b010) ||
                     (bus.funct == 3'b100) || (bus.funct == 3'b111));

  // State register: synchronous reset wins over RUN and MemReady.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic: RUN=0 freezes; HALT is left only through RESET.
  always_comb begin
    state_d = state_q;
    if (bus.RUN) begin
      case (state_q)
        S_FETCH:   if (mem_rdy) state_d = S_LINK;
        S_LINK:    state_d = S_DECODE;
        S_DECODE: begin
          case (bus.op)
            2'b11: begin
              case (bus.funct)
                3'b010:        state_d = S_LDI;
                3'b000, 3'b100: state_d = S_MEMADR;
                3'b111:        state_d = S_HALT;
                default:       state_d = S_FETCH;
              endcase
            end
            2'b10:   state_d = S_ALU;
            2'b01:   state_d = S_SHIFT;
            default: state_d = (bus.funct == 3'b111) ? S_BXLR : S_BRANCH;
          endcase
        end
        S_MEMADR:  state_d = (bus.funct == 3'b100) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (mem_rdy) state_d = S_MEMWB;
        S_MEMWR:   if (mem_rdy) state_d = S_FETCH;
        S_ALU:     state_d = S_ALUWB;
        S_SHIFT:   state_d = S_SHIFTWB;
        S_LDI, S_MEMWB, S_ALUWB, S_SHIFTWB, S_BRANCH, S_BXLR:
                   state_d = S_FETCH;
        S_HALT:    state_d = S_HALT;
        default:   state_d = S_FETCH;
      endcase
    end
  end

  logic pcw, adr, memw, irw, rs1, rs2, regw, asa, lrw, wsel, fw1, fw2;
  logic halted, ill, ret;
  logic [1:0] asb;
  logic [2:0] aluc, ress;

  // Output decode: raw controls from state and instruction fields, all default 0.
  always_comb begin
    pcw = 1'b0; adr = 1'b0; memw = 1'b0; irw = 1'b0; rs1 = 1'b0; rs2 = 1'b0;
    regw = 1'b0; asa = 1'b0; lrw = 1'b0; wsel = 1'b0; fw1 = 1'b0; fw2 = 1'b0;
    halted = 1'b0; ill = 1'b0; ret = 1'b0;
    asb = 2'b00; aluc = 3'b000; ress = 3'b000;
    case (state_q)
      S_FETCH: begin
        asa = 1'b1; asb = 2'b10; ress = 3'b010;
        pcw = mem_rdy; irw = mem_rdy;
      end
      S_LINK:
        lrw = (bus.op == 2'b00) && ((bus.funct == 3'b001) || (bus.funct == 3'b010));
      S_DECODE: begin
        asa = 1'b1; asb = 2'b10; ress = 3'b010;
        rs2 = ((bus.op == 2'b11) && (bus.funct == 3'b100)) || (bus.op == 2'b01);
        rs1 = (bus.op == 2'b00) && (bus.funct != 3'b010) && (bus.funct != 3'b111);
        ill = illegal;
      end
      S_ALU: begin
        aluc = bus.funct;
        fw1  = bus.S;
        fw2  = bus.S && ((bus.funct == 3'b000) || (bus.funct == 3'b001));
      end
      S_MEMADR: asb = 2'b01;
      S_MEMRD:  adr = 1'b1;
      S_MEMWR: begin
        adr = 1'b1; memw = 1'b1; ret = mem_rdy;
      end
      S_BRANCH: begin
        asb = 2'b01; ress = 3'b010; pcw = br_taken; ret = 1'b1;
      end
      S_BXLR: begin
        pcw = 1'b1; wsel = 1'b1; ret = 1'b1;
      end
      S_LDI: begin
        regw = 1'b1; ress = 3'b100; pcw = rd_is_pc; ret = 1'b1;
      end
      S_MEMWB: begin
        regw = 1'b1; ress = 3'b001; pcw = rd_is_pc; ret = 1'b1;
      end
      S_ALUWB: begin
        regw = 1'b1; ress = 3'b000; pcw = rd_is_pc; ret = 1'b1;
      end
      S_SHIFTWB: begin
        regw = 1'b1; ress = 3'b011; pcw = rd_is_pc; ret = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // Pause gating: enables and pulses drop with RUN=0, mux selects do not.
  assign bus.PCWrite      = bus.RUN & pcw;
  assign bus.IRWrite      = bus.RUN & irw;
  assign bus.RegWrite     = bus.RUN & regw;
  assign bus.MemWrite     = bus.RUN & memw;
  assign bus.LRWrite      = bus.RUN & lrw;
  assign bus.FlagW1       = bus.RUN & fw1;
  assign bus.FlagW2       = bus.RUN & fw2;
  assign bus.InstrRetired = bus.RUN & ret;
  assign bus.IllegalOp    = bus.RUN & ill;
  assign bus.AdrSrc       = adr;
  assign bus.RegSrc1      = rs1;
  assign bus.RegSrc2      = rs2;
  assign bus.ALUSrcA      = asa;
  assign bus.WriteSelect  = wsel;
  assign bus.ALUSrcB      = asb;
  assign bus.ALUControl   = aluc;
  assign bus.ResultSrc    = ress;
  assign bus.Halted       = halted;
  assign bus.StateNumber  = state_q;

endmodule
